uart_receiver: RTL and testbench

//  Asynchronous serial (8N1) receiver. It is the receive-side counterpart of the board UART transmitter.

---
 rtl/uart_receiver.sv | 182 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver with 16x oversampling, framing-error and break handling.
// Define UART_RX_PARITY_EN for 8E1 framing with a perr strobe.
module uart_receiver #(
  parameter int CLKFREQ = 100_000_000,
  parameter int BAUD    = 9_600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       rdy,
  output logic       ferr
`ifdef UART_RX_PARITY_EN
  ,
  output logic       perr
`endif
);

  localparam int OSDIV = CLKFREQ / (BAUD * 16);
  localparam int TW    = (OSDIV > 1) ? $clog2(OSDIV) : 1;

  generate
    if (OSDIV < 1) begin : g_osdiv_check
      $error("uart_receiver: CLKFREQ/(BAUD*16) must be >= 1");
    end
  endgenerate

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;
`endif

  state_t        state_reg;
  logic [1:0]    sync_reg;
  logic          rxs;
  logic [TW-1:0] tick_cnt_reg;
  logic          os_tick;
  logic [3:0]    os_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [7:0]    shreg_reg;

  // Two-flop synchronizer; resets to the idle (high) line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg <= 2'b11;
    end else begin
      sync_reg <= {sync_reg[0], rxd};
    end
  end

  assign rxs     = sync_reg[1];
  assign os_tick = (tick_cnt_reg == TW'(OSDIV - 1));

  // Held at zero while idle so the first tick lands one divider period after the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_reg <= '0;
    end else if (state_reg == IDLE || os_tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + TW'(1);
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_reg;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      os_cnt_reg  <= 4'd0;
      bit_cnt_reg <= 3'd0;
      shreg_reg   <= 8'h00;
      data        <= 8'h00;
      rdy         <= 1'b0;
      ferr        <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_reg     <= 1'b0;
      perr        <= 1'b0;
`endif
    end else begin
      rdy  <= 1'b0;
      ferr <= 1'b0;
`ifdef UART_RX_PARITY_EN
      perr <= 1'b0;
`endif
      case (state_reg)
        IDLE: begin
          os_cnt_reg  <= 4'd0;
          bit_cnt_reg <= 3'd0;
          if (!rxs) begin
            state_reg <= START;
          end
        end

        START: begin
          if (os_tick) begin
            if (os_cnt_reg == 4'd7) begin
              os_cnt_reg <= 4'd0;
              // A start bit that is gone by mid-bit was a glitch.
              state_reg  <= rxs ? IDLE : DATA;
            end else begin
              os_cnt_reg <= os_cnt_reg + 4'd1;
            end
          end
        end

        DATA: begin
          if (os_tick) begin
            if (os_cnt_reg == 4'd15) begin
              os_cnt_reg  <= 4'd0;
              shreg_reg   <= {rxs, shreg_reg[7:1]};
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (bit_cnt_reg == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state_reg <= PARITY;
`else
                state_reg <= STOP;
`endif
              end
            end else begin
              os_cnt_reg <= os_cnt_reg + 4'd1;
            end
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (os_tick) begin
            if (os_cnt_reg == 4'd15) begin
              os_cnt_reg <= 4'd0;
              par_reg    <= rxs;
              state_reg  <= STOP;
            end else begin
              os_cnt_reg <= os_cnt_reg + 4'd1;
            end
          end
        end
`endif

        STOP: begin
          if (os_tick) begin
            if (os_cnt_reg == 4'd15) begin
              os_cnt_reg <= 4'd0;
              if (!rxs) begin
                ferr      <= 1'b1;
                state_reg <= BREAK;
              end else begin
                // Returning to IDLE mid-stop-bit lets an immediate next start edge be caught.
                state_reg <= IDLE;
`ifdef UART_RX_PARITY_EN
                if (^{shreg_reg, par_reg}) begin
                  perr <= 1'b1;
                end else begin
                  data <= shreg_reg;
                  rdy  <= 1'b1;
                end
`else
                data <= shreg_reg;
                rdy  <= 1'b1;
`endif
              end
            end else begin
              os_cnt_reg <= os_cnt_reg + 4'd1;
            end
          end
        end

        BREAK: begin
          if (rxs) begin
            state_reg <= IDLE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at 16 clk per bit (OSDIV=1).
// Build with +define+UART_RX_PARITY_EN to also exercise the parity path.
module tb_uart_receiver;

  localparam int KIND_RDY  = 0;
  localparam int KIND_FERR = 1;
  localparam int KIND_PERR = 2;

  typedef struct {
    int         kind;
    logic [7:0] d;
  } ev_t;

  logic       clk;
  logic       rst;
  logic       rxd;
  logic [7:0] data;
  logic       rdy;
  logic       ferr;
  logic       perr_w;

  ev_t exp_q[$];
  int  n_checks;
  int  n_fails;

  uart_receiver #(
    .CLKFREQ(100_000_000),
    .BAUD   (6_250_000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .rxd (rxd),
    .data(data),
    .rdy (rdy),
`ifdef UART_RX_PARITY_EN
    .ferr(ferr),
    .perr(perr_w)
`else
    .ferr(ferr)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign perr_w = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("check %s: %h ok", name, act);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] d);
    ev_t e;
    e.kind = kind;
    e.d    = d;
    exp_q.push_back(e);
  endtask

  task automatic line_bit(input logic v, input int clks);
    rxd = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v);
    line_bit(1'b0, 16);
    for (int i = 0; i < 8; i++) line_bit(b[i], 16);
`ifdef UART_RX_PARITY_EN
    line_bit(par_v, 16);
`endif
    line_bit(stop_v, 16);
  endtask

  // Monitor: every output strobe must match the head of the expected queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (rdy && ferr) begin
        n_checks++;
        n_fails++;
        $display("FAIL rdy_ferr_overlap: rdy=%b ferr=%b required not both", rdy, ferr);
      end
      if (rdy || ferr || perr_w) begin
        int  kind;
        ev_t e;
        kind = rdy ? KIND_RDY : (ferr ? KIND_FERR : KIND_PERR);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fails++;
          $display("FAIL unexpected_strobe: kind %0d data %h, none expected", kind, data);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != kind || e.d !== data) begin
            n_fails++;
            $display("FAIL strobe: kind %0d data %h, required kind %0d data %h",
                     kind, data, e.kind, e.d);
          end else begin
            $display("strobe kind %0d data %h ok", kind, data);
          end
        end
      end
    end
  end

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    rxd      = 1'b1;
    repeat (4) @(negedge clk);
    chk("reset_data", data, 8'h00);
    chk("reset_rdy", {7'd0, rdy}, 8'h00);
    chk("reset_ferr", {7'd0, ferr}, 8'h00);
    rst = 1'b0;
    line_bit(1'b1, 20);

    // 1: single frame
    expect_ev(KIND_RDY, 8'hAE);
    send_frame(8'hAE, 1'b1, 1'b1);
    line_bit(1'b1, 32);

    // 2: back-to-back frames, no idle gap
    expect_ev(KIND_RDY, 8'h2A);
    expect_ev(KIND_RDY, 8'hAE);
    send_frame(8'h2A, 1'b1, 1'b1);
    send_frame(8'hAE, 1'b1, 1'b1);
    line_bit(1'b1, 32);

    // 3: short glitch rejected, then a good frame
    line_bit(1'b0, 4);
    line_bit(1'b1, 32);
    expect_ev(KIND_RDY, 8'h55);
    send_frame(8'h55, 1'b1, 1'b0);
    line_bit(1'b1, 32);

    // 4: stop bit low, line held low -> one ferr, data unchanged
    expect_ev(KIND_FERR, 8'h55);
    send_frame(8'h3C, 1'b0, 1'b0);
    line_bit(1'b0, 40);
    line_bit(1'b1, 48);

    // 5: reset in the middle of bit 4 of 0xFF
    line_bit(1'b0, 16);
    for (int i = 0; i < 4; i++) line_bit(1'b1, 16);
    line_bit(1'b1, 8);
    rst = 1'b1;
    #1;
    chk("midreset_data", data, 8'h00);
    chk("midreset_rdy", {7'd0, rdy}, 8'h00);
    chk("midreset_ferr", {7'd0, ferr}, 8'h00);
    @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    line_bit(1'b1, 20);
    expect_ev(KIND_RDY, 8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    line_bit(1'b1, 32);

`ifdef UART_RX_PARITY_EN
    // 6: correct even parity, then a bad parity bit
    expect_ev(KIND_RDY, 8'hAE);
    send_frame(8'hAE, 1'b1, 1'b1);
    line_bit(1'b1, 32);
    expect_ev(KIND_PERR, 8'hAE);
    send_frame(8'hAE, 1'b1, 1'b0);
    line_bit(1'b1, 32);
`endif

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fails++;
      $display("FAIL missing_strobes: %0d outstanding, required 0", exp_q.size());
    end else begin
      $display("check all expected strobes seen ok");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
